// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte-stream
// requesters. A round-robin scheduler picks one requester per byte, runs the
// transmitter's STROBE/FULL handshake and pulses ACK once the frame is out.
// Optional packet lock (keeps a multi-byte message contiguous with an
// idle-owner timeout) is built when UART_TX_ARB_LOCK_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NUM_REQ-1:0]   REQ,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]   REQ_LAST,
  output logic [NUM_REQ-1:0]   ACK,
  output logic [ID_W-1:0]      GRANT_ID,
  output logic                 BUSY,
  output logic [7:0]           TX_DATA,
  output logic                 TX_STROBE,
  input  logic                 TX_FULL
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t               state_r, state_nxt_s;
  logic [ID_W-1:0]      ptr_r, ptr_nxt_s;
  logic [ID_W-1:0]      grant_r, grant_nxt_s;
  logic [7:0]           tx_data_r, tx_data_nxt_s;
  logic                 tx_strobe_r, tx_strobe_nxt_s;
  logic [NUM_REQ-1:0]   ack_r, ack_nxt_s;
  logic                 busy_r, busy_nxt_s;
  logic [NUM_REQ-1:0]   elig_s;
  logic [ID_W-1:0]      win_s;
  logic                 win_found_s;
  logic                 byte_done_s;
  logic                 lock_nxt_s;

`ifdef UART_TX_ARB_LOCK_EN
  localparam int TOUT_W = $clog2(LOCK_TIMEOUT + 1);

  logic              lock_r;
  logic [TOUT_W-1:0] tout_r, tout_nxt_s;

  // Eligible set: while a packet is locked only its owner may be granted.
  always_comb begin
    elig_s = {NUM_REQ{1'b0}};
    if (lock_r) begin
      elig_s[grant_r] = REQ[grant_r];
    end else begin
      elig_s = REQ;
    end
  end

  // Lock update on byte completion, plus the idle-owner force-release timer.
  always_comb begin
    lock_nxt_s = lock_r;
    tout_nxt_s = tout_r;
    if (byte_done_s) begin
      lock_nxt_s = ~REQ_LAST[grant_r];
      tout_nxt_s = {TOUT_W{1'b0}};
    end else if (lock_r && (state_r != SEND) && !REQ[grant_r]) begin
      if (tout_r == TOUT_W'(LOCK_TIMEOUT - 1)) begin
        lock_nxt_s = 1'b0;
        tout_nxt_s = {TOUT_W{1'b0}};
      end else begin
        tout_nxt_s = tout_r + TOUT_W'(1);
      end
    end else begin
      tout_nxt_s = {TOUT_W{1'b0}};
    end
  end

  // Lock flag and timeout counter registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      lock_r <= 1'b0;
      tout_r <= {TOUT_W{1'b0}};
    end else begin
      lock_r <= lock_nxt_s;
      tout_r <= tout_nxt_s;
    end
  end
`else
  // Without packet lock every byte is arbitrated on its own.
  logic unused_last_s;
  assign unused_last_s = ^REQ_LAST;
  assign elig_s        = REQ;
  assign lock_nxt_s    = 1'b0;
`endif

  // Cyclic first-eligible search starting at the round-robin pointer.
  always_comb begin
    int cand_v;
    win_found_s = 1'b0;
    win_s       = {ID_W{1'b0}};
    cand_v      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_v = int'(ptr_r) + k;
      cand_v = (cand_v >= NUM_REQ) ? (cand_v - NUM_REQ) : cand_v;
      if (!win_found_s && elig_s[ID_W'(cand_v)]) begin
        win_found_s = 1'b1;
        win_s       = ID_W'(cand_v);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state and registered-output values of the grant/handshake FSM.
  always_comb begin
    state_nxt_s     = state_r;
    ptr_nxt_s       = ptr_r;
    grant_nxt_s     = grant_r;
    tx_data_nxt_s   = tx_data_r;
    tx_strobe_nxt_s = tx_strobe_r;
    ack_nxt_s       = {NUM_REQ{1'b0}};
    byte_done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (win_found_s) begin
          tx_data_nxt_s   = REQ_DATA[{win_s, 3'b000} +: 8];
          grant_nxt_s     = win_s;
          tx_strobe_nxt_s = 1'b1;
          state_nxt_s     = SEND;
        end else begin
          tx_strobe_nxt_s = 1'b0;
        end
      end
      SEND: begin
        // FULL low means the frame, stop bit included, has left the wire.
        if (!TX_FULL) begin
          tx_strobe_nxt_s    = 1'b0;
          ack_nxt_s[grant_r] = 1'b1;
          ptr_nxt_s          = (grant_r == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}}
                                                               : grant_r + ID_W'(1);
          byte_done_s        = 1'b1;
          state_nxt_s        = RELEASE;
        end else begin
          tx_strobe_nxt_s = 1'b1;
        end
      end
      RELEASE: begin
        // One low-STROBE cycle lets the transmitter leave its complete state.
        tx_strobe_nxt_s = 1'b0;
        state_nxt_s     = IDLE;
      end
      default: begin
        tx_strobe_nxt_s = 1'b0;
        state_nxt_s     = IDLE;
      end
    endcase
    busy_nxt_s = (state_nxt_s != IDLE) | lock_nxt_s;
  end

  // FSM state, pointer and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= IDLE;
      ptr_r       <= {ID_W{1'b0}};
      grant_r     <= {ID_W{1'b0}};
      tx_data_r   <= 8'h00;
      tx_strobe_r <= 1'b0;
      ack_r       <= {NUM_REQ{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      ptr_r       <= ptr_nxt_s;
      grant_r     <= grant_nxt_s;
      tx_data_r   <= tx_data_nxt_s;
      tx_strobe_r <= tx_strobe_nxt_s;
      ack_r       <= ack_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign ACK       = ack_r;
  assign GRANT_ID  = grant_r;
  assign BUSY      = busy_r;
  assign TX_DATA   = tx_data_r;
  assign TX_STROBE = tx_strobe_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a behavioural
// UART transmitter (4 cycles per bit, 40-cycle frame). Lock scenarios are
// compiled in when UART_TX_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic [N-1:0]   REQ = 4'h0;
  logic [8*N-1:0] REQ_DATA = 32'h0;
  logic [N-1:0]   REQ_LAST = 4'h0;
  logic [N-1:0]   ACK;
  logic [1:0]     GRANT_ID;
  logic           BUSY;
  logic [7:0]     TX_DATA;
  logic           TX_STROBE;
  logic           TX_FULL;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(16)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_DATA(REQ_DATA),
    .REQ_LAST(REQ_LAST), .ACK(ACK), .GRANT_ID(GRANT_ID), .BUSY(BUSY),
    .TX_DATA(TX_DATA), .TX_STROBE(TX_STROBE), .TX_FULL(TX_FULL)
  );

  initial forever #5 CLK = ~CLK;

  // Cycle counter used to time-stamp logged events.
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural UART: 0 idle, 1 frame, 2 complete (waits for STROBE low).
  logic [1:0] u_state = 2'd0;
  logic [5:0] u_cnt = 6'd0;
  logic [9:0] u_frame = 10'h3FF;
  logic [9:0] u_cap = 10'h000;
  logic       txd;
  logic [9:0] wire_q[$];

  assign TX_FULL = ((u_state == 2'd0) && TX_STROBE) || (u_state == 2'd1);
  assign txd     = (u_state == 2'd1) ? u_frame[u_cnt[5:2]] : 1'b1;

  // Transmitter model and mid-bit wire decoder.
  always @(posedge CLK) begin
    if (RESET) begin
      u_state <= 2'd0;
      u_cnt   <= 6'd0;
    end else begin
      case (u_state)
        2'd0: if (TX_STROBE) begin
          u_state <= 2'd1;
          u_cnt   <= 6'd0;
          u_frame <= {1'b1, TX_DATA, 1'b0};
        end
        2'd1: begin
          if (u_cnt[1:0] == 2'd2) u_cap[u_cnt[5:2]] <= txd;
          if (u_cnt == 6'd39) begin
            u_state <= 2'd2;
            wire_q.push_back(u_cap);
          end
          u_cnt <= u_cnt + 6'd1;
        end
        2'd2: if (!TX_STROBE) u_state <= 2'd0;
        default: u_state <= 2'd0;
      endcase
    end
  end

  // Requester model: each requester walks its byte list, advancing on ACK.
  logic [7:0] byte_mem[N][8];
  logic       last_mem[N][8];
  int         n_bytes[N];
  int         idx[N];
  logic [N-1:0] drop_mask = 4'h0;

  initial begin
    for (int i = 0; i < N; i++) begin n_bytes[i] = 0; idx[i] = 0; end
    forever begin
      @(negedge CLK);
      #1;
      for (int i = 0; i < N; i++) begin
        if (ACK[i] && idx[i] < n_bytes[i]) idx[i]++;
        if (idx[i] < n_bytes[i] && !drop_mask[i]) begin
          REQ[i] = 1'b1;
          REQ_DATA[8*i +: 8] = byte_mem[i][idx[i]];
          REQ_LAST[i] = last_mem[i][idx[i]];
        end else begin
          REQ[i] = 1'b0;
          REQ_DATA[8*i +: 8] = 8'h00;
          REQ_LAST[i] = 1'b0;
        end
      end
    end
  end

  // Event logs: ACK pulses and TX_STROBE rising edges.
  int         ack_cyc[$];
  logic [3:0] ack_vec[$];
  logic       ack_stb[$];
  int         rise_cyc[$];
  logic [1:0] rise_gid[$];
  logic       stb_prev = 1'b0;

  initial forever begin
    @(negedge CLK);
    if (!RESET) begin
      if (ACK != 4'h0) begin
        ack_cyc.push_back(cyc);
        ack_vec.push_back(ACK);
        ack_stb.push_back(TX_STROBE);
      end
      if (TX_STROBE && !stb_prev) begin
        rise_cyc.push_back(cyc);
        rise_gid.push_back(GRANT_ID);
      end
    end
    stb_prev = TX_STROBE;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running required finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int r, input int k, input logic [7:0] b, input logic l);
    byte_mem[r][k] = b;
    last_mem[r][k] = l;
  endtask

  task automatic clear_logs();
    ack_cyc.delete(); ack_vec.delete(); ack_stb.delete();
    rise_cyc.delete(); rise_gid.delete(); wire_q.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    drop_mask = 4'h0;
    for (int i = 0; i < N; i++) begin n_bytes[i] = 0; idx[i] = 0; end
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    clear_logs();
  endtask

  function automatic logic all_done();
    logic d = 1'b1;
    for (int i = 0; i < N; i++) if (idx[i] < n_bytes[i]) d = 1'b0;
    return d;
  endfunction

  task automatic wait_strobe(input string tag);
    int k = 0;
    while (!TX_STROBE && k < 200) begin @(negedge CLK); k++; end
    check({tag, " strobe timeout"}, {31'd0, TX_STROBE}, 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    logic ok;
    @(negedge CLK);
    while (!(all_done() && !BUSY) && k < budget) begin @(negedge CLK); k++; end
    ok = all_done() && !BUSY;
    check({tag, " done timeout"}, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int k;
    do_reset();
    check("reset strobe", {31'd0, TX_STROBE}, 32'd0);
    check("reset data", {24'd0, TX_DATA}, 32'h00);
    check("reset ack", {28'd0, ACK}, 32'h0);
    check("reset gid", {30'd0, GRANT_ID}, 32'd0);
    check("reset busy", {31'd0, BUSY}, 32'd0);

    // T1: requester 2 alone, byte 0x55.
    @(negedge CLK);
    load(2, 0, 8'h55, 1'b1);
    n_bytes[2] = 1;
    #2 check("t1 strobe before grant", {31'd0, TX_STROBE}, 32'd0);
    @(negedge CLK);
    check("t1 strobe latency", {31'd0, TX_STROBE}, 32'd1);
    check("t1 gid", {30'd0, GRANT_ID}, 32'd2);
    check("t1 data", {24'd0, TX_DATA}, 32'h55);
    check("t1 busy", {31'd0, BUSY}, 32'd1);
    wait_done("t1", 200);
    check("t1 ack count", ack_vec.size(), 32'd1);
    check("t1 ack vec", {28'd0, ack_vec[0]}, 32'h4);
    check("t1 strobe at ack", {31'd0, ack_stb[0]}, 32'd0);
    check("t1 wire count", wire_q.size(), 32'd1);
    check("t1 wire frame", {22'd0, wire_q[0]}, 32'h2AA);

    // T2: all four requesting, round-robin order and 2-cycle ACK-to-STROBE gap.
    do_reset();
    @(negedge CLK);
    load(0, 0, 8'hA0, 1'b1); load(0, 1, 8'hA0, 1'b1);
    load(1, 0, 8'hA1, 1'b1); load(2, 0, 8'hA2, 1'b1); load(3, 0, 8'hA3, 1'b1);
    n_bytes[0] = 2; n_bytes[1] = 1; n_bytes[2] = 1; n_bytes[3] = 1;
    wait_done("t2", 400);
    check("t2 wire count", wire_q.size(), 32'd5);
    check("t2 rise count", rise_gid.size(), 32'd5);
    check("t2 ack count", ack_vec.size(), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2 wire byte %0d", i), {24'd0, wire_q[i][8:1]}, 32'hA0 + (i % 4));
      check($sformatf("t2 grant %0d", i), {30'd0, rise_gid[i]}, i % 4);
      check($sformatf("t2 ack vec %0d", i), {28'd0, ack_vec[i]}, 32'd1 << (i % 4));
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("t2 gap %0d", i), rise_cyc[i+1] - ack_cyc[i], 32'd2);

    // T3: reset at data bit 4, then REQ[1] and REQ[2] together.
    do_reset();
    @(negedge CLK);
    load(1, 0, 8'h3C, 1'b1);
    n_bytes[1] = 1;
    k = 0;
    while (!(u_state == 2'd1 && u_cnt == 6'd21) && k < 200) begin @(negedge CLK); k++; end
    check("t3 reach bit4", {31'd0, (u_state == 2'd1 && u_cnt == 6'd21)}, 32'd1);
    check("t3 busy before reset", {31'd0, BUSY}, 32'd1);
    RESET = 1'b1;
    for (int i = 0; i < N; i++) begin n_bytes[i] = 0; idx[i] = 0; end
    @(negedge CLK);
    check("t3 strobe after reset", {31'd0, TX_STROBE}, 32'd0);
    check("t3 ack after reset", {28'd0, ACK}, 32'h0);
    check("t3 busy after reset", {31'd0, BUSY}, 32'd0);
    check("t3 gid after reset", {30'd0, GRANT_ID}, 32'd0);
    RESET = 1'b0;
    @(negedge CLK);
    clear_logs();
    load(1, 0, 8'h61, 1'b1); load(2, 0, 8'h62, 1'b1);
    n_bytes[1] = 1; n_bytes[2] = 1;
    wait_done("t3", 300);
    check("t3 rise count", rise_gid.size(), 32'd2);
    check("t3 first grant", {30'd0, rise_gid[0]}, 32'd1);
    check("t3 second grant", {30'd0, rise_gid[1]}, 32'd2);
    check("t3 wire first", {24'd0, wire_q[0][8:1]}, 32'h61);

    // T4: REQ[0] dropped during SEND; byte still completes once.
    do_reset();
    @(negedge CLK);
    load(0, 0, 8'h81, 1'b1);
    n_bytes[0] = 1;
    wait_strobe("t4");
    drop_mask = 4'h1;
    wait_done("t4", 200);
    repeat (20) @(negedge CLK);
    check("t4 ack count", ack_vec.size(), 32'd1);
    check("t4 ack vec", {28'd0, ack_vec[0]}, 32'h1);
    check("t4 rise count", rise_gid.size(), 32'd1);
    check("t4 wire byte", {24'd0, wire_q[0][8:1]}, 32'h81);
    drop_mask = 4'h0;

`ifdef UART_TX_ARB_LOCK_EN
    // T5: requester 1 sends a 3-byte packet while requester 0 waits.
    do_reset();
    @(negedge CLK);
    load(1, 0, 8'h11, 1'b0); load(1, 1, 8'h12, 1'b0); load(1, 2, 8'h13, 1'b1);
    n_bytes[1] = 3;
    wait_strobe("t5");
    load(0, 0, 8'h20, 1'b1);
    n_bytes[0] = 1;
    wait_done("t5", 400);
    check("t5 wire count", wire_q.size(), 32'd4);
    check("t5 wire 0", {24'd0, wire_q[0][8:1]}, 32'h11);
    check("t5 wire 1", {24'd0, wire_q[1][8:1]}, 32'h12);
    check("t5 wire 2", {24'd0, wire_q[2][8:1]}, 32'h13);
    check("t5 wire 3", {24'd0, wire_q[3][8:1]}, 32'h20);

    // T6: requester 3 leaves an open packet; lock times out after 16 cycles.
    do_reset();
    @(negedge CLK);
    load(3, 0, 8'h33, 1'b0);
    n_bytes[3] = 1;
    wait_strobe("t6");
    load(0, 0, 8'h44, 1'b1);
    n_bytes[0] = 1;
    wait_done("t6", 400);
    check("t6 rise count", rise_gid.size(), 32'd2);
    check("t6 first grant", {30'd0, rise_gid[0]}, 32'd3);
    check("t6 second grant", {30'd0, rise_gid[1]}, 32'd0);
    check("t6 timeout gap", rise_cyc[1] - ack_cyc[0], 32'd17);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
